disp_scan_ctrl: RTL
===================

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD digits, range 2..8.
REQ-002 SHALL have parameter SCAN_DIV, default 50000, i_clk cycles per digit scan tick, minimum 2.
REQ-003 SHALL have parameter BLINK_FRAMES, default 32, full scan frames per blink half-period, minimum 1.
REQ-004 SHALL have port i_clk, input, 1: single clock, rising-edge.
REQ-005 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port i_data, input, 4*DIGITS: BCD value, digit 0 in bits [3:0].
REQ-007 SHALL have port i_load, input, 1: one-cycle strobe capturing i_data and i_blink_mask.
REQ-008 SHALL have port i_blink_mask, input, DIGITS: per-digit blink enable.
REQ-009 SHALL have port i_phase, input, 2: light phase; 0 red, 1 yellow, 2 green, 3 yellow-flash.
REQ-010 SHALL have port o_an, output, DIGITS: active-low one-hot digit select.
REQ-011 SHALL have port o_seg_data, output, 4: BCD of the selected digit.
REQ-012 SHALL have port o_seg_blank, output, 1: 1 means the selected digit is dark.
REQ-013 SHALL have port o_led, output, 3: {red, yellow, green}, active-high.

Function
REQ-014 SHALL register i_data and i_blink_mask into shadow registers on the cycle i_load=1; the display reads only the shadow registers.
REQ-015 SHALL pulse the scan tick for one cycle every SCAN_DIV cycles, counter 0..SCAN_DIV-1, wrapping to 0.
REQ-016 SHALL advance the digit index on each scan tick, DIGITS-1 wrapping to 0; the wrap ends one frame.
REQ-017 SHALL toggle blink_on after BLINK_FRAMES completed frames, then clear the frame counter.
REQ-018 SHALL register o_an, o_seg_data and o_seg_blank, updating them one cycle after the index changes.
REQ-019 SHALL drive o_seg_blank=1 when the selected digit's shadow mask bit is 1 and blink_on=0.
REQ-020 SHALL, when i_load coincides with a scan tick, display the old shadow value in that cycle and the new value from the next cycle; the index is not reset.
REQ-021 SHALL decode o_led combinationally from i_phase: 0 gives 100, 1 gives 010, 2 gives 001, 3 gives {0, blink_on, 0}.
REQ-022 SHALL pass shadow digit values above 9 to o_seg_data unmodified; they are never blanked by REQ-027.

Reset
REQ-023 SHALL, while i_rst_n=0, force: o_an all ones, o_seg_data 0, o_seg_blank 1.
REQ-024 SHALL, while i_rst_n=0, force: index 0, prescaler 0, frame counter 0, blink_on 1, shadows 0.
REQ-025 SHALL resume after reset release with the first scan tick SCAN_DIV cycles later, even if reset was asserted mid-frame.

Configuration
REQ-026 SHALL implement leading-zero blanking only when the macro DISP_LZB_EN is defined.
REQ-027 SHALL, with DISP_LZB_EN defined, blank each zero digit above which all higher digits are also zero; digit 0 is never blanked.
REQ-028 SHALL, without DISP_LZB_EN, show all zero digits; REQ-019 blanking still applies.

Structure
REQ-029 SHALL place the phase encodings (PH_RED, PH_YEL, PH_GRN, PH_FLASH) and the LED constants in package disp_pkg.
REQ-030 SHALL implement the tick generator as sub-module disp_prescaler, with parameter DIV and ports i_clk, i_rst_n, o_tick.

Verification (run with SCAN_DIV=4, BLINK_FRAMES=2, DIGITS=4)
REQ-031 SHALL check: after reset release, o_an steps 1110, 1101, 1011, 0111, 1110 every 4 cycles, and the first step occurs 4 cycles after release.
REQ-032 SHALL check: load 0x0042 with DISP_LZB_EN defined; digits 3 and 2 blank, digit 1 shows 4, digit 0 shows 2.
REQ-033 SHALL check: load 0x0000 with DISP_LZB_EN defined; only digit 0 is unblanked and shows 0.
REQ-034 SHALL check: load 0x1234 with mask 0001; digit 0 blanks on alternate 2-frame periods, and no other digit blanks.
REQ-035 SHALL check: i_phase=3 gives o_led toggling between 010 and 000 every 2 frames; i_phase=0 gives a steady 100.
REQ-036 SHALL check: i_load of 0x5678 on a scan-tick cycle gives the old digit in that cycle and the new digit from the next cycle; then reset asserted mid-frame forces o_an to 1111 immediately.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants for the display scan controller: light phase encodings,
// LED patterns and the phase-to-LED decode.
package disp_pkg;

    typedef enum logic [1:0] {
        PH_RED   = 2'd0,
        PH_YEL   = 2'd1,
        PH_GRN   = 2'd2,
        PH_FLASH = 2'd3
    } phase_e;

    // LED vectors are {red, yellow, green}, active-high.
    localparam logic [2:0] LED_RED = 3'b100;
    localparam logic [2:0] LED_YEL = 3'b010;
    localparam logic [2:0] LED_GRN = 3'b001;
    localparam logic [2:0] LED_OFF = 3'b000;

    function automatic logic [2:0] led_decode(input logic [1:0] phase, input logic blink_on);
        logic [2:0] led;
        led = LED_OFF;
        case (phase_e'(phase))
            PH_RED:   led = LED_RED;
            PH_YEL:   led = LED_YEL;
            PH_GRN:   led = LED_GRN;
            PH_FLASH: led = blink_on ? LED_YEL : LED_OFF;
            default:  led = LED_OFF;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Free-running divider: o_tick is high for one cycle out of every DIV cycles,
// the first one DIV cycles after reset release.
module disp_prescaler #(
    parameter int DIV = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        o_tick = (cnt_q == CW'(DIV - 1));
        cnt_d  = o_tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed BCD display scanner with per-digit blinking and traffic-light LEDs.
// Define DISP_LZB_EN to enable leading-zero blanking.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [4*DIGITS-1:0]   i_data,
    input  logic                  i_load,
    input  logic [DIGITS-1:0]     i_blink_mask,
    input  logic [1:0]            i_phase,
    output logic [DIGITS-1:0]     o_an,
    output logic [3:0]            o_seg_data,
    output logic                  o_seg_blank,
    output logic [2:0]            o_led
);

    localparam int IW = $clog2(DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic                  tick;
    logic                  frame_end;
    logic [3:0]            cur_digit;
    logic [DIGITS-1:0]     lz_blank;

    logic [4*DIGITS-1:0]   data_q, data_d;
    logic [DIGITS-1:0]     mask_q, mask_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [FW-1:0]         frame_q, frame_d;
    logic                  blink_q, blink_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [3:0]            seg_q, seg_d;
    logic                  blank_q, blank_d;

    disp_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_tick  (tick)
    );

`ifdef DISP_LZB_EN
    logic lz_all;

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        lz_all   = 1'b1;
        lz_blank = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lz_all      = lz_all & (data_q[4*i +: 4] == 4'd0);
            lz_blank[i] = lz_all;
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        data_d    = data_q;
        mask_d    = mask_q;
        idx_d     = idx_q;
        frame_d   = frame_q;
        blink_d   = blink_q;
        cur_digit = 4'd0;
        frame_end = tick && (idx_q == IW'(DIGITS - 1));

        if (i_load) begin
            data_d = i_data;
            mask_d = i_blink_mask;
        end

        if (tick) begin
            idx_d = frame_end ? '0 : idx_q + 1'b1;
        end

        if (frame_end) begin
            if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end

        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_digit = data_q[4*i +: 4];
            end
        end

        // Outputs follow the index one cycle late and see the shadows as of that cycle.
        an_d    = ~(DIGITS'(1) << idx_q);
        seg_d   = cur_digit;
        blank_d = (mask_q[idx_q] & ~blink_q) | lz_blank[idx_q];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q  <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            blink_q <= 1'b1;
            an_q    <= '1;
            seg_q   <= 4'd0;
            blank_q <= 1'b1;
        end else begin
            data_q  <= data_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            blank_q <= blank_d;
        end
    end

    assign o_an        = an_q;
    assign o_seg_data  = seg_q;
    assign o_seg_blank = blank_q;
    assign o_led       = led_decode(i_phase, blink_q);

endmodule
